freq_range_ctrl: RTL and testbench
==================================

# freq_range_ctrl

Autoranging measurement sequencer for the frequency detector. It controls the ADC sample-rate divider, restarts the detector after every rate change and waits for a stable period reading. It steps the divider until the period (in samples) lies inside a target window, then returns the period and divider setting to the host with a one-cycle `done` pulse. It sits between the host/MCU register interface and the detector/ADC-clock divider.

## Interface
- `PERIOD_W`, 12: width of the detector period.
- `DIV_W`, 3: width of the divider select. ADC sample rate = clk / 2^div_sel.
- `DIV_MAX`, 7: highest legal div_sel.
- `DIV_INIT`, 0: div_sel after reset.
- `PERIOD_LO`, 64: lower bound of the in-range window, inclusive.
- `PERIOD_HI`, 2048: upper bound of the in-range window, inclusive.
- `SETTLE_CYCLES`, 16: wait after a detector clear, in clk cycles, ≥1.
- `TIMEOUT_CYCLES`, 65536: maximum wait for `det_stable`, ≥2.
- `MAX_STEPS`, 8: maximum divider changes per measurement.

Ports:
- `clk` in 1: single clock; the detector and the ADC divider logic run on it.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a measurement. Sampled only in IDLE.
- `abort` in 1: cancel a running measurement.
- `det_stable` in 1: detector period is valid and stable.
- `det_period` in PERIOD_W: detector period, in samples.
- `det_clr` out 1: one-cycle restart pulse to the detector.
- `div_sel` out DIV_W: ADC sample-rate divider select.
- `busy` out 1: high from the cycle after start is accepted until DONE exits.
- `done` out 1: one-cycle completion pulse.
- `result_period` out PERIOD_W: last accepted period.
- `result_div` out DIV_W: div_sel used for `result_period`.
- `err_range` out 1: finished without reaching the window.
- `err_timeout` out 1: `det_stable` never arrived.

## Operation
- Reset values: state IDLE; div_sel = DIV_INIT; every other output 0; step and timer counters 0.
- States: IDLE, CLEAR, SETTLE, WAIT_STABLE, CHECK, DONE.
- **IDLE**
  - `start` = 1: clear `err_range` and `err_timeout`, set step = 0, go to CLEAR.
  - div_sel keeps its last value, so each measurement starts from the previous range.
- **CLEAR**: `det_clr` = 1 for exactly this cycle, load the timer with SETTLE_CYCLES-1, go to SETTLE.
- **SETTLE**: count down. At 0, load the timer with TIMEOUT_CYCLES-1 and go to WAIT_STABLE.
- **WAIT_STABLE**
  - `det_stable` = 1: latch `det_period` into an internal register p, go to CHECK.
  - Timer at 0 with `det_stable` = 0: set `err_timeout`, go to DONE.
  - If `det_stable` is high in the same cycle the timer reaches 0, `det_stable` wins.
- **CHECK** (p = 0 counts as below range):
  - PERIOD_LO ≤ p ≤ PERIOD_HI: accept.
  - p < PERIOD_LO: sampling is too slow. If div_sel > 0 and step < MAX_STEPS, decrement div_sel. Otherwise set `err_range` and accept.
  - p > PERIOD_HI: sampling is too fast. If div_sel < DIV_MAX and step < MAX_STEPS, increment div_sel. Otherwise set `err_range` and accept.
  - After any div_sel change: step++, go to CLEAR.
  - Accept: `result_period` = p, `result_div` = div_sel, go to DONE.
- **DONE**: `done` = 1 for one cycle, go to IDLE.
  - `result_*` and `err_*` hold until the next accepted start.
  - On timeout, `result_*` is not updated.
- **abort**: in any state other than IDLE, go to IDLE next cycle.
  - No `done` pulse; div_sel keeps its current value; results are untouched.
  - abort has priority over every other transition.
- `start` outside IDLE is ignored; it is not queued.
- Comparisons are unsigned at PERIOD_W bits.
- div_sel never leaves the range 0..DIV_MAX.

## Timing
- `start` at cycle 0 → CLEAR and `det_clr` at cycle 1; `busy` = 1 from cycle 1.
- WAIT_STABLE is entered at cycle 2+SETTLE_CYCLES.
- `det_stable` seen at cycle k → CHECK at k+1 → DONE, with `done` = 1, at k+2.
- `busy` falls in the cycle after DONE, which is also the first IDLE cycle.
- A back-to-back `start` is accepted in that first IDLE cycle.
- A range step (CHECK → CLEAR) costs 1 cycle; the new div_sel is visible in the same cycle as the following `det_clr`.
- Timeout: with no `det_stable`, DONE occurs TIMEOUT_CYCLES cycles after entering WAIT_STABLE.
- `rst` mid-measurement: all outputs return to reset values on the next edge, including div_sel = DIV_INIT.

## Test plan
1. In range on the first try: DIV_INIT = 2; `start`; `det_stable` held high with `det_period` = 400. Expect one `det_clr`, `done` at WAIT_STABLE entry + 2, `result_period` = 400, `result_div` = 2, both `err_*` = 0.
2. Downranging: DIV_INIT = 3; the detector reports 40 while div_sel ≥ 2 and 160 at div_sel = 1. Expect div_sel 3→2→1, three `det_clr` pulses, `result_period` = 160, `result_div` = 1.
3. Saturation: div_sel = DIV_MAX and `det_period` = 4095. Expect no step, `err_range` = 1, `result_div` = 7, `result_period` = 4095. With div_sel = 0 and `det_period` = 0: `err_range` = 1 and `result_period` = 0.
4. Timeout: TIMEOUT_CYCLES = 100, `det_stable` held low. Expect `done` exactly 100 cycles after WAIT_STABLE entry, `err_timeout` = 1, `result_*` unchanged.
5. Control: `abort` during SETTLE gives IDLE next cycle and no `done`. `start` pulsed while busy is ignored. `rst` during WAIT_STABLE gives div_sel = DIV_INIT and all outputs 0.

Source files
------------

// File: rtl/freq_range_ctrl.sv
// Autoranging measurement sequencer: steps the ADC divider until the detector
// period lands inside [PERIOD_LO, PERIOD_HI], then reports it with a done pulse.
module freq_range_ctrl #(
    parameter int unsigned PERIOD_W       = 12,
    parameter int unsigned DIV_W          = 3,
    parameter int unsigned DIV_MAX        = 7,
    parameter int unsigned DIV_INIT       = 0,
    parameter int unsigned PERIOD_LO      = 64,
    parameter int unsigned PERIOD_HI      = 2048,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_STEPS      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                det_stable,
    input  logic [PERIOD_W-1:0] det_period,
    output logic                det_clr,
    output logic [DIV_W-1:0]    div_sel,
    output logic                busy,
    output logic                done,
    output logic [PERIOD_W-1:0] result_period,
    output logic [DIV_W-1:0]    result_div,
    output logic                err_range,
    output logic                err_timeout,
    output logic [2:0]          dbg_state
);

    localparam int unsigned T_MAX  = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TMR_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int unsigned STEP_W = (MAX_STEPS > 0) ? $clog2(MAX_STEPS + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_SETTLE = 3'd2,
        S_WAIT   = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [PERIOD_W-1:0] p_q, p_d;
    logic [PERIOD_W-1:0] res_p_q, res_p_d;
    logic [DIV_W-1:0]    res_div_q, res_div_d;
    logic                err_r_q, err_r_d;
    logic                err_t_q, err_t_d;
    logic                accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= DIV_W'(DIV_INIT);
            step_q    <= '0;
            timer_q   <= '0;
            p_q       <= '0;
            res_p_q   <= '0;
            res_div_q <= '0;
            err_r_q   <= 1'b0;
            err_t_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            step_q    <= step_d;
            timer_q   <= timer_d;
            p_q       <= p_d;
            res_p_q   <= res_p_d;
            res_div_q <= res_div_d;
            err_r_q   <= err_r_d;
            err_t_q   <= err_t_d;
        end
    end

    // Host handshake: start is a request sampled only in IDLE (no queueing,
    // no backpressure); done is a one-cycle completion pulse with results valid.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        step_d    = step_q;
        timer_d   = timer_q;
        p_d       = p_q;
        res_p_d   = res_p_q;
        res_div_d = res_div_q;
        err_r_d   = err_r_q;
        err_t_d   = err_t_q;
        accept    = 1'b0;
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        err_r_d = 1'b0;
                        err_t_d = 1'b0;
                        step_d  = '0;
                        state_d = S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    timer_d = TMR_W'(SETTLE_CYCLES - 1);
                    state_d = S_SETTLE;
                end
                S_SETTLE: begin
                    if (timer_q == '0) begin
                        timer_d = TMR_W'(TIMEOUT_CYCLES - 1);
                        state_d = S_WAIT;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                S_WAIT: begin
                    // A stable reading on the last timer cycle still counts.
                    if (det_stable) begin
                        p_d     = det_period;
                        state_d = S_CHECK;
                    end else if (timer_q == '0) begin
                        err_t_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                S_CHECK: begin
                    if (p_q < PERIOD_W'(PERIOD_LO)) begin
                        if (div_q != '0 && step_q < STEP_W'(MAX_STEPS)) begin
                            div_d   = div_q - DIV_W'(1);
                            step_d  = step_q + STEP_W'(1);
                            state_d = S_CLEAR;
                        end else begin
                            err_r_d = 1'b1;
                            accept  = 1'b1;
                        end
                    end else if (p_q > PERIOD_W'(PERIOD_HI)) begin
                        if (div_q < DIV_W'(DIV_MAX) && step_q < STEP_W'(MAX_STEPS)) begin
                            div_d   = div_q + DIV_W'(1);
                            step_d  = step_q + STEP_W'(1);
                            state_d = S_CLEAR;
                        end else begin
                            err_r_d = 1'b1;
                            accept  = 1'b1;
                        end
                    end else begin
                        accept = 1'b1;
                    end
                    if (accept) begin
                        res_p_d   = p_q;
                        res_div_d = div_q;
                        state_d   = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        det_clr = (state_q == S_CLEAR);
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
    end

    assign div_sel       = div_q;
    assign result_period = res_p_q;
    assign result_div    = res_div_q;
    assign err_range     = err_r_q;
    assign err_timeout   = err_t_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_freq_range_ctrl.sv
// Bench for freq_range_ctrl: a detector model driven by a per-divider period table,
// a whole-measurement reference model feeding an expected queue, and a done monitor.
module tb_freq_range_ctrl;

    localparam int PW       = 12;
    localparam int DW       = 3;
    localparam int SETTLE   = 16;
    localparam int TMO      = 100;
    localparam int DIV_INIT = 2;
    localparam int DIV_MAX  = 7;
    localparam int LO       = 64;
    localparam int HI       = 2048;
    localparam int MAXS     = 8;
    localparam int EXP_W    = 44;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          det_stable;
    logic [PW-1:0] det_period;
    logic          det_clr;
    logic [DW-1:0] div_sel;
    logic          busy;
    logic          done;
    logic [PW-1:0] result_period;
    logic [DW-1:0] result_div;
    logic          err_range;
    logic          err_timeout;
    logic [2:0]    dbg_state;

    freq_range_ctrl #(
        .PERIOD_W(PW), .DIV_W(DW), .DIV_MAX(DIV_MAX), .DIV_INIT(DIV_INIT),
        .PERIOD_LO(LO), .PERIOD_HI(HI), .SETTLE_CYCLES(SETTLE),
        .TIMEOUT_CYCLES(TMO), .MAX_STEPS(MAXS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .det_stable(det_stable), .det_period(det_period), .det_clr(det_clr),
        .div_sel(div_sel), .busy(busy), .done(done),
        .result_period(result_period), .result_div(result_div),
        .err_range(err_range), .err_timeout(err_timeout), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- detector model ----------------
    int per_div[8];
    int dly     = 0;
    int clr_cnt = 0;

    always @(posedge clk) begin
        if (det_clr) clr_cnt <= 0;
        else if (clr_cnt < 100000) clr_cnt <= clr_cnt + 1;
    end
    assign det_stable = (clr_cnt >= dly);
    assign det_period = PW'(per_div[div_sel]);

    // ---------------- scoreboard state ----------------
    logic [EXP_W-1:0] exp_q[$];
    int n_chk  = 0;
    int n_fail = 0;
    int m_div, m_res_p, m_res_div, m_err_r, m_err_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_div = DIV_INIT; m_res_p = 0; m_res_div = 0; m_err_r = 0; m_err_t = 0;
    endtask

    // Plays out a whole measurement from the period table and the stable delay.
    task automatic model_meas(input int d, output logic [EXP_W-1:0] e);
        int div, steps, p, lat, nclr, len;
        bit fin;
        div = m_div; steps = 0; p = 0; fin = 0;
        m_err_r = 0; m_err_t = 0;
        if (d > SETTLE + TMO - 1) begin
            m_err_t = 1;
            nclr = 1;
            lat = 2 + SETTLE + TMO;
        end else begin
            len = SETTLE + 3 + ((d > SETTLE) ? d - SETTLE : 0);
            while (!fin) begin
                p = per_div[div];
                if (p >= LO && p <= HI) fin = 1;
                else if (p < LO) begin
                    if (div > 0 && steps < MAXS) begin div--; steps++; end
                    else begin m_err_r = 1; fin = 1; end
                end else begin
                    if (div < DIV_MAX && steps < MAXS) begin div++; steps++; end
                    else begin m_err_r = 1; fin = 1; end
                end
            end
            m_div = div; m_res_p = p; m_res_div = div;
            nclr = steps + 1;
            lat = nclr * len + 1;
        end
        e = {16'(lat), 8'(nclr), 1'(m_err_t), 1'(m_err_r), 3'(m_div), 3'(m_res_div), 12'(m_res_p)};
    endtask

    // ---------------- monitor ----------------
    int mon_lat = 0;
    int mon_clr = 0;

    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (rst || !busy) begin
            mon_lat = 0; mon_clr = 0;
        end else begin
            mon_lat++;
            if (det_clr) mon_clr++;
        end
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("result_period", result_period, e[11:0]);
                check("result_div",    result_div,    e[14:12]);
                check("div_sel",       div_sel,       e[17:15]);
                check("err_range",     err_range,     e[18]);
                check("err_timeout",   err_timeout,   e[19]);
                check("det_clr_count", mon_clr,       e[27:20]);
                check("done_latency",  mon_lat,       e[43:28]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic fill(input int v);
        for (int i = 0; i < 8; i++) per_div[i] = v;
    endtask

    task automatic set_sig(input int sig);
        for (int i = 0; i < 8; i++) per_div[i] = ((sig >> i) > 4095) ? 4095 : (sig >> i);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("wait_idle_bound", 1, 0);
    endtask

    task automatic do_meas(input int d, input bit extra_start);
        logic [EXP_W-1:0] e;
        dly = d;
        model_meas(d, e);
        exp_q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (extra_start) begin
            repeat (6) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},    busy,          0);
        check({tag, "_done"},    done,          0);
        check({tag, "_det_clr"}, det_clr,       0);
        check({tag, "_state"},   dbg_state,     0);
        check({tag, "_div_sel"}, div_sel,       m_div);
        check({tag, "_res_p"},   result_period, m_res_p);
        check({tag, "_res_div"}, result_div,    m_res_div);
        check({tag, "_err_r"},   err_range,     m_err_r);
        check({tag, "_err_t"},   err_timeout,   m_err_t);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cls, n;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        fill(400);
        model_reset();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // In range on the first try at the initial divider.
        fill(400);
        do_meas(0, 0);

        // Step up once to reach div 3, then downrange 3 -> 2 -> 1.
        fill(3000); per_div[3] = 1500;
        do_meas(5, 0);
        fill(40); per_div[1] = 160; per_div[0] = 10;
        do_meas(0, 0);

        // Saturation at both ends of the divider range.
        fill(4095);
        do_meas(0, 0);
        fill(0);
        do_meas(0, 0);

        // Oscillating detector exhausts the step budget.
        fill(1000); per_div[0] = 3000; per_div[1] = 10;
        do_meas(0, 0);

        // Stable on the very last timeout cycle, then one cycle too late.
        fill(500);
        do_meas(SETTLE + TMO - 1, 0);
        do_meas(SETTLE + TMO, 0);

        // Ignored start while busy.
        fill(900);
        do_meas(3, 1);

        // Abort during SETTLE: back to IDLE, no done, results kept.
        dly = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_pre_state", dbg_state, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        m_err_r = 0; m_err_t = 0;
        check_idle_outputs("abort");
        repeat (30) @(negedge clk);

        // Randomized measurements.
        for (int k = 0; k < 40; k++) begin
            cls = $urandom_range(0, 4);
            case (cls)
                0: set_sig($urandom_range(0, 120));
                1, 2: set_sig($urandom_range(200, 300000));
                3: set_sig($urandom_range(300000, 1000000));
                default: for (int i = 0; i < 8; i++) per_div[i] = $urandom_range(0, 4095);
            endcase
            do_meas(($urandom_range(0, 9) < 8) ? $urandom_range(0, 40) : $urandom_range(110, 125),
                    ($urandom_range(0, 4) == 0));
        end

        // Reset in the middle of WAIT_STABLE.
        dly = 500;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (dbg_state != 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_wait_state", dbg_state, 3);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        check_idle_outputs("mid_rst");
        rst = 1'b0;
        @(negedge clk);

        // Normal operation resumes from the reset divider.
        fill(700);
        do_meas(2, 0);

        repeat (5) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
